// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
// Contents: opcode and funct field values, ALU operation codes,
// FSM state encodings, and the mux-select encodings driven by the controller.
package mips_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field values (R-type)
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // ALU operation codes (widened to ALU_W at the output)
  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_NOR = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_ADD = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;

  // FSM state encodings; 4'hF is unused and recovers to S_FETCH
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_ALU_WB    = 4'd7;
  localparam logic [3:0] S_IMM_EXEC  = 4'd8;
  localparam logic [3:0] S_IMM_WB    = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;
  localparam logic [3:0] S_JAL       = 4'd12;
  localparam logic [3:0] S_JR        = 4'd13;
  localparam logic [3:0] S_ILLEGAL   = 4'd14;

  // alu_src_b selects
  localparam logic [2:0] SRCB_REG     = 3'd0;
  localparam logic [2:0] SRCB_FOUR    = 3'd1;
  localparam logic [2:0] SRCB_IMM     = 3'd2;
  localparam logic [2:0] SRCB_IMM_SH2 = 3'd3;
  localparam logic [2:0] SRCB_ZIMM    = 3'd4;

  // pc_src selects
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REGA   = 2'd3;

  // reg_dst selects
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // mem_to_reg selects
  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  // True for R-type funct values that execute through the ALU (jr excluded)
  function automatic logic funct_is_alu(input logic [5:0] funct);
    case (funct)
      F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT:
        funct_is_alu = 1'b1;
      default:
        funct_is_alu = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation decoder for the multi-cycle MIPS controller.
// Ports:
//   state       in  4      current controller state
//   op          in  6      opcode field
//   funct       in  6      funct field
//   alu_control out ALU_W  ALU operation code (0 where the state uses no ALU op)
// ALU_W must be at least 3 to hold the largest code (SUB=6).
module mips_alu_dec
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_W = 4
) (
  input  logic [3:0]       state,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic [ALU_W-1:0] alu_control
);

  logic [2:0] code;

  always_comb begin
    code = ALU_AND;
    case (state)
      S_FETCH, S_DECODE, S_MEM_ADDR: code = ALU_ADD;
      S_BRANCH:                      code = ALU_SUB;
      S_R_EXEC: begin
        case (funct)
          F_ADD, F_ADDU: code = ALU_ADD;
          F_SUB, F_SUBU: code = ALU_SUB;
          F_AND:         code = ALU_AND;
          F_OR:          code = ALU_OR;
          F_XOR:         code = ALU_XOR;
          F_NOR:         code = ALU_NOR;
          F_SLT:         code = ALU_SLT;
          default:       code = ALU_AND;
        endcase
      end
      S_IMM_EXEC: begin
        case (op)
          OP_ADDI: code = ALU_ADD;
          OP_SLTI: code = ALU_SLT;
          OP_ANDI: code = ALU_AND;
          OP_ORI:  code = ALU_OR;
          OP_XORI: code = ALU_XOR;
          default: code = ALU_AND;
        endcase
      end
      default: code = ALU_AND;
    endcase
  end

  assign alu_control = ALU_W'(code);

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller: FSM plus combinational output decode.
// Ports:
//   clk, rstb          clock; synchronous active-low reset
//   op, funct          instruction register fields
//   mem_ready          memory completes the current access this cycle
//   alu_control        ALU op (from mips_alu_dec)
//   alu_src_a/_b       ALU operand selects
//   pc_src, pc_write   PC source select and unconditional load
//   branch, branch_ne  conditional PC load on ALU zero / not zero
//   reg_write, reg_dst, mem_to_reg   register-file write controls
//   i_or_d, mem_read, mem_write      memory address select and strobes
//   ir_write           instruction register load
//   illegal_op         one-cycle pulse on an undecodable instruction
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALU_W      = 4,
  parameter bit          ENABLE_JAL = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic [ALU_W-1:0] alu_control,
  output logic             alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_write,
  output logic             branch,
  output logic             branch_ne,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             illegal_op
);

  logic [3:0] state;
  logic [3:0] state_next;

  // Raw strobes before reset gating
  logic pc_write_raw, branch_raw, branch_ne_raw, reg_write_raw;
  logic mem_read_raw, mem_write_raw, ir_write_raw, illegal_raw;

  always_ff @(posedge clk) begin
    if (!rstb) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct == F_JR)           state_next = S_JR;
            else if (funct_is_alu(funct)) state_next = S_R_EXEC;
            else                         state_next = S_ILLEGAL;
          end
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                          state_next = S_IMM_EXEC;
          OP_J:           state_next = S_JUMP;
          OP_JAL:         state_next = ENABLE_JAL ? S_JAL : S_ILLEGAL;
          default:        state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_next = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_IMM_EXEC:  state_next = S_IMM_WB;
      S_IMM_WB:    state_next = S_FETCH;
      S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL:
                   state_next = S_FETCH;
      default:     state_next = S_FETCH;
    endcase
  end

  always_comb begin
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU;
    reg_dst       = DST_RT;
    mem_to_reg    = WB_ALUOUT;
    i_or_d        = 1'b0;
    pc_write_raw  = 1'b0;
    branch_raw    = 1'b0;
    branch_ne_raw = 1'b0;
    reg_write_raw = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    illegal_raw   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE:    alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        i_or_d       = 1'b1;
        mem_read_raw = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = DST_RT;
        mem_to_reg    = WB_MEM;
      end
      S_MEM_WRITE: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REG;
      end
      S_ALU_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = DST_RD;
      end
      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = (op == OP_ADDI || op == OP_SLTI) ? SRCB_IMM : SRCB_ZIMM;
      end
      S_IMM_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = DST_RT;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_REG;
        pc_src        = PCSRC_ALUOUT;
        branch_raw    = (op == OP_BEQ);
        branch_ne_raw = (op == OP_BNE);
      end
      S_JUMP: begin
        pc_src       = PCSRC_JUMP;
        pc_write_raw = 1'b1;
      end
      S_JAL: begin
        pc_src        = PCSRC_JUMP;
        pc_write_raw  = 1'b1;
        reg_write_raw = 1'b1;
        reg_dst       = DST_RA;
        mem_to_reg    = WB_PC;
      end
      S_JR: begin
        pc_src       = PCSRC_REGA;
        pc_write_raw = 1'b1;
      end
      S_ILLEGAL:   illegal_raw = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated by rstb directly so they drop in the same cycle reset is
  // asserted, before the synchronous state reset takes effect.
  assign pc_write   = pc_write_raw  & rstb;
  assign branch     = branch_raw    & rstb;
  assign branch_ne  = branch_ne_raw & rstb;
  assign reg_write  = reg_write_raw & rstb;
  assign mem_read   = mem_read_raw  & rstb;
  assign mem_write  = mem_write_raw & rstb;
  assign ir_write   = ir_write_raw  & rstb;
  assign illegal_op = illegal_raw   & rstb;

  mips_alu_dec #(
    .ALU_W(ALU_W)
  ) u_alu_dec (
    .state      (state),
    .op         (op),
    .funct      (funct),
    .alu_control(alu_control)
  );

endmodule
